display_share_arbiter: RTL and testbench



---
 rtl/display_share_arbiter_if.sv | 22 ++
 rtl/display_share_arbiter.sv | 103 ++++++++++
 tb/tb_display_share_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/display_share_arbiter_if.sv
// Bus between the two display requesters and the display share arbiter.
// Handshake: req[k] is a level request held by requester k for as long as it wants the
// display. grant is one-hot and shows the current owner. A requester may drop req at any
// time to release the display. digits and new_owner are registered outputs of the arbiter.
interface display_share_arbiter_if;
  logic [1:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [1:0]  grant;
  logic [31:0] digits;
  logic        new_owner;

  modport master (
    output req, data0, data1,
    input  grant, digits, new_owner
  );

  modport slave (
    input  req, data0, data1,
    output grant, digits, new_owner
  );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin owner selection with a minimum-hold timer for the shared eight-digit display.
// The owner's word is registered onto digits one cycle after the grant is decoded.
module display_share_arbiter #(
  parameter int             HOLD_CYCLES  = 100000000,
  parameter int             CW           = 27,
  parameter logic [31:0]    IDLE_PATTERN = 32'h00000000
) (
  input  logic                      ck,
  input  logic                      reset,
  display_share_arbiter_if.slave    bus,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          expired;
  logic          enter;
  logic          new_owner_q;
  logic [31:0]   digits_q;

  assign expired = (cnt == CNT_MAX);
  // Any move into a grant state, including a direct handover, is an entry.
  assign enter   = (state_nxt != state) && (state_nxt != IDLE);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        case (bus.req)
          2'b01:   state_nxt = G0;
          2'b10:   state_nxt = G1;
          2'b11:   state_nxt = last ? G0 : G1;
          default: state_nxt = IDLE;
        endcase
      end
      G0: begin
        if (!bus.req[0])                state_nxt = bus.req[1] ? G1 : IDLE;
        else if (expired && bus.req[1]) state_nxt = G1;
        else                            state_nxt = G0;
      end
      G1: begin
        if (!bus.req[1])                state_nxt = bus.req[0] ? G0 : IDLE;
        else if (expired && bus.req[0]) state_nxt = G0;
        else                            state_nxt = G1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      last        <= 1'b1;
      new_owner_q <= 1'b0;
      digits_q    <= IDLE_PATTERN;
    end else begin
      new_owner_q <= enter;
      if (enter) begin
        cnt  <= '0;
        last <= (state_nxt == G1);
      end else if (state != IDLE && !expired) begin
        cnt <= cnt + 1'b1;
      end
      // digits follows the owner that was valid during this cycle.
      case (state)
        G0:      digits_q <= bus.data0;
        G1:      digits_q <= bus.data1;
        default: digits_q <= IDLE_PATTERN;
      endcase
    end
  end

  always_comb begin
    bus.grant     = 2'b00;
    bus.digits    = digits_q;
    bus.new_owner = new_owner_q;
    dbg_state     = state;
    case (state)
      G0:      bus.grant = 2'b01;
      G1:      bus.grant = 2'b10;
      default: bus.grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an owner/age model of the sharing rules.
module tb_display_share_arbiter;

  localparam int          HOLD = 4;
  localparam logic [31:0] IDLE_PAT = 32'h00000000;

  logic ck = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  display_share_arbiter_if ifc ();
  display_share_arbiter_if ifc1 ();

  assign ifc1.req   = ifc.req;
  assign ifc1.data0 = ifc.data0;
  assign ifc1.data1 = ifc.data1;

  display_share_arbiter #(.HOLD_CYCLES(HOLD), .CW(3), .IDLE_PATTERN(IDLE_PAT)) dut (
    .ck(ck), .reset(reset), .bus(ifc.slave), .dbg_state(dbg_state)
  );

  display_share_arbiter #(.HOLD_CYCLES(1), .CW(1), .IDLE_PATTERN(IDLE_PAT)) dut1 (
    .ck(ck), .reset(reset), .bus(ifc1.slave), .dbg_state(dbg_state1)
  );

  // clock / reset
  always #5 ck = ~ck;

  // behavioural model: owner is -1 when nobody holds the display
  int          owner  = -1;
  int          age    = 0;
  int          last_k = 1;
  logic        exp_new = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp = IDLE_PAT;

  always @(posedge ck or posedge reset) begin : model
    int nxt;
    logic [1:0] r;
    if (reset) begin
      owner   = -1;
      age     = 0;
      last_k  = 1;
      exp_new = 1'b0;
      exp_q.delete();
      cur_exp = IDLE_PAT;
    end else begin
      r = ifc.req;
      exp_q.push_back(owner == 0 ? ifc.data0 : (owner == 1 ? ifc.data1 : IDLE_PAT));
      nxt = owner;
      if (owner < 0) begin
        if (r == 2'b11)  nxt = 1 - last_k;
        else if (r[0])   nxt = 0;
        else if (r[1])   nxt = 1;
      end else if (!r[owner]) begin
        nxt = r[1-owner] ? 1 - owner : -1;
      end else if (age >= HOLD - 1 && r[1-owner]) begin
        nxt = 1 - owner;
      end
      exp_new = (nxt >= 0) && (nxt != owner);
      if (exp_new) begin
        age    = 0;
        last_k = nxt;
      end else if (owner >= 0) begin
        age++;
      end
      owner = nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge ck) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      check("model_grant", {30'd0, ifc.grant},
            owner == 0 ? 32'd1 : (owner == 1 ? 32'd2 : 32'd0));
      check("model_digits", ifc.digits, cur_exp);
      check("model_new_owner", {31'd0, ifc.new_owner}, {31'd0, exp_new});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_req(input logic [1:0] r);
    ifc.req = r;
  endtask

  initial begin
    ifc.req   = 2'b00;
    ifc.data0 = 32'h0;
    ifc.data1 = 32'h0;
    chk_en    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) tick();
    check("idle_grant", {30'd0, ifc.grant}, 32'd0);
    check("idle_digits", ifc.digits, IDLE_PAT);
    check("idle_new_owner", {31'd0, ifc.new_owner}, 32'd0);

    // tie from idle: requester 0 first, then alternation every HOLD cycles
    ifc.data0 = 32'hE5D00814;
    ifc.data1 = 32'h12345678;
    set_req(2'b11);
    tick();
    check("tie_grant", {30'd0, ifc.grant}, 32'd1);
    check("tie_new_owner", {31'd0, ifc.new_owner}, 32'd1);
    check("h1_grant_e1", {30'd0, ifc1.grant}, 32'd1);
    tick();
    check("tie_digits", ifc.digits, 32'hE5D00814);
    check("tie_pulse_end", {31'd0, ifc.new_owner}, 32'd0);
    check("h1_grant_e2", {30'd0, ifc1.grant}, 32'd2);
    tick();
    check("hold_grant", {30'd0, ifc.grant}, 32'd1);
    check("h1_grant_e3", {30'd0, ifc1.grant}, 32'd1);
    tick();
    tick();
    check("preempt_grant", {30'd0, ifc.grant}, 32'd2);
    check("preempt_new_owner", {31'd0, ifc.new_owner}, 32'd1);
    tick();
    check("preempt_digits", ifc.digits, 32'h12345678);
    for (int i = 0; i < 8; i++) tick();

    // requester 0 alone, data changes mid-hold
    set_req(2'b01);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 8) ifc.data0 = 32'hAAAA5555;
      tick();
      if (i == 8) check("live_data", ifc.digits, 32'hAAAA5555);
    end
    check("solo_grant", {30'd0, ifc.grant}, 32'd1);

    // late request from requester 1 waits for the hold timer
    set_req(2'b00);
    tick();
    set_req(2'b01);
    tick();
    tick();
    set_req(2'b11);
    tick();
    check("wait_cnt2", {30'd0, ifc.grant}, 32'd1);
    tick();
    check("wait_cnt3", {30'd0, ifc.grant}, 32'd1);
    tick();
    check("late_switch", {30'd0, ifc.grant}, 32'd2);
    check("late_new_owner", {31'd0, ifc.new_owner}, 32'd1);
    tick();
    check("late_pulse_end", {31'd0, ifc.new_owner}, 32'd0);

    // voluntary release to idle, then direct handover
    set_req(2'b01);
    tick();
    set_req(2'b00);
    tick();
    check("release_grant", {30'd0, ifc.grant}, 32'd0);
    tick();
    check("release_digits", ifc.digits, IDLE_PAT);
    set_req(2'b01);
    tick();
    set_req(2'b10);
    tick();
    check("handover_grant", {30'd0, ifc.grant}, 32'd2);
    check("handover_new_owner", {31'd0, ifc.new_owner}, 32'd1);

    // asynchronous reset mid-G1
    #2;
    reset = 1'b1;
    #1;
    check("areset_grant", {30'd0, ifc.grant}, 32'd0);
    check("areset_digits", ifc.digits, IDLE_PAT);
    check("areset_new_owner", {31'd0, ifc.new_owner}, 32'd0);
    @(posedge ck);
    #1;
    reset = 1'b0;
    set_req(2'b11);
    tick();
    check("post_reset_tie", {30'd0, ifc.grant}, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) ifc.req = 2'($urandom_range(0, 3));
      ifc.data0 = $urandom;
      ifc.data1 = $urandom;
      tick();
    end

    @(negedge ck);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
